isp1761_bus_responder: RTL and testbench

- Synthesizable responder for the ISP1761 parallel host bus: the chip side of the asynchronous CS_N/WR_N/RD_N/A/D interface.
- Used in the testbench build as a stand-in for the USB controller.
- Provides a register window, host and device interrupts, and DREQ/DACK DMA pacing.
- Oversamples the asynchronous strobes on a local clock.

---
 rtl/isp1761_bus_responder.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_isp1761_bus_responder.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/isp1761_bus_responder.sv
// isp1761_bus_responder: chip side of the ISP1761 asynchronous host bus.
// Oversamples CS_N/WR_N/RD_N on csi_clk, serves a 16 x 32-bit register
// window, raises HC/DC interrupts and paces DMA through DREQ/DACK.
// Ports:
//   csi_clk, rsi_rst_n       local clock, synchronous active-low reset
//   bus_cs_n/wr_n/rd_n       asynchronous bus strobes, active low
//   bus_a[16:0]              halfword address A[17:1]
//   bus_d[31:0]              data bus, driven only while bus_d_oe=1
//   bus_hc_irq/bus_dc_irq    registered OR of enabled status bits
//   bus_hc_dreq/bus_dc_dreq  DMA request, high while the count is nonzero
//   bus_hc_dack/bus_dc_dack  DMA acknowledge, sampled like the strobes
//   evt_hc/evt_dc            one-cycle pulses that set status bits
//   bus_d_oe                 data-drive indicator
//   proto_err                sticky: RD_N and WR_N low together under CS_N
module isp1761_bus_responder #(
    parameter logic [31:0] CHIP_ID     = 32'h0001_1761,
    parameter int          RD_LAT      = 2,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        csi_clk,
    input  logic        rsi_rst_n,
    input  logic        bus_cs_n,
    input  logic        bus_wr_n,
    input  logic        bus_rd_n,
    input  logic [16:0] bus_a,
    inout  wire  [31:0] bus_d,
    output logic        bus_hc_irq,
    output logic        bus_dc_irq,
    output logic        bus_hc_dreq,
    output logic        bus_dc_dreq,
    input  logic        bus_hc_dack,
    input  logic        bus_dc_dack,
    input  logic [7:0]  evt_hc,
    input  logic [7:0]  evt_dc,
    output logic        bus_d_oe,
    output logic        proto_err
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ACTIVE,
        RD_WAIT,
        RD_DRIVE,
        ERR
    } state_t;

    localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

    // A1 only picks a halfword inside a 32-bit register, so it is dropped.
    logic a0_unused;
    assign a0_unused = bus_a[0];

    logic [SYNC_STAGES-1:0] cs_sh, wr_sh, rd_sh;
    logic [SYNC_STAGES-1:0] hk_sh, dk_sh, vld_sh;
    logic [15:0] a_sh [SYNC_STAGES];
    logic [31:0] d_sh [SYNC_STAGES];

    logic        cs_s, wr_s, rd_s, hk_s, dk_s, vld_s;
    logic [15:0] a_s, a_prev;
    logic [31:0] d_s, d_prev;

    always_ff @(posedge csi_clk) begin
        if (!rsi_rst_n) begin
            cs_sh  <= '1;
            wr_sh  <= '1;
            rd_sh  <= '1;
            hk_sh  <= '0;
            dk_sh  <= '0;
            vld_sh <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                a_sh[i] <= '0;
                d_sh[i] <= '0;
            end
            a_prev <= '0;
            d_prev <= '0;
        end else begin
            cs_sh  <= {cs_sh[SYNC_STAGES-2:0], bus_cs_n};
            wr_sh  <= {wr_sh[SYNC_STAGES-2:0], bus_wr_n};
            rd_sh  <= {rd_sh[SYNC_STAGES-2:0], bus_rd_n};
            hk_sh  <= {hk_sh[SYNC_STAGES-2:0], bus_hc_dack};
            dk_sh  <= {dk_sh[SYNC_STAGES-2:0], bus_dc_dack};
            vld_sh <= {vld_sh[SYNC_STAGES-2:0], 1'b1};
            a_sh[0] <= bus_a[16:1];
            d_sh[0] <= bus_d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                a_sh[i] <= a_sh[i-1];
                d_sh[i] <= d_sh[i-1];
            end
            a_prev <= a_s;
            d_prev <= d_s;
        end
    end

    assign cs_s  = cs_sh[SYNC_STAGES-1];
    assign wr_s  = wr_sh[SYNC_STAGES-1];
    assign rd_s  = rd_sh[SYNC_STAGES-1];
    assign hk_s  = hk_sh[SYNC_STAGES-1];
    assign dk_s  = dk_sh[SYNC_STAGES-1];
    assign vld_s = vld_sh[SYNC_STAGES-1];
    assign a_s   = a_sh[SYNC_STAGES-1];
    assign d_s   = d_sh[SYNC_STAGES-1];

    // The synchronizer resets to "idle high", so a strobe that was held
    // low through reset must first be seen high on real samples.
    logic armed;

    always_ff @(posedge csi_clk) begin
        if (!rsi_rst_n) begin
            armed <= 1'b0;
        end else if (vld_s && (cs_s || (rd_s && wr_s))) begin
            armed <= 1'b1;
        end
    end

    logic sel, both_low;
    assign sel      = armed && !cs_s;
    assign both_low = sel && !rd_s && !wr_s;

    state_t state_q, state_d;
    logic   wr_commit, rd_start, rd_fire, rd_release, err_set;
    logic [2:0] lat_cnt;

    always_ff @(posedge csi_clk) begin
        if (!rsi_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_commit  = 1'b0;
        rd_start   = 1'b0;
        rd_fire    = 1'b0;
        rd_release = 1'b0;
        err_set    = 1'b0;
        if (both_low) begin
            state_d = ERR;
            err_set = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (sel && !wr_s && rd_s) begin
                        state_d = WR_ACTIVE;
                    end else if (sel && !rd_s && wr_s) begin
                        state_d  = RD_WAIT;
                        rd_start = 1'b1;
                    end
                end
                WR_ACTIVE: begin
                    // a_prev/d_prev still hold the last strobe-low sample
                    if (wr_s || cs_s) begin
                        wr_commit = 1'b1;
                        state_d   = IDLE;
                    end
                end
                RD_WAIT: begin
                    if (rd_s || cs_s) begin
                        state_d = IDLE;
                    end else if (lat_cnt == 3'd0) begin
                        rd_fire = 1'b1;
                        state_d = RD_DRIVE;
                    end
                end
                RD_DRIVE: begin
                    if (rd_s || cs_s) begin
                        rd_release = 1'b1;
                        state_d    = IDLE;
                    end
                end
                ERR: begin
                    if (rd_s && wr_s) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Register file
    logic [31:0] scratch;
    logic [7:0]  hc_sts, hc_en, dc_sts, dc_en;
    logic [15:0] dma_cnt;
    logic        dma_ch;
    logic [31:0] gp [7:15];

    logic        w_hit;
    logic [3:0]  w_idx;
    logic [7:0]  hc_clr, dc_clr;

    assign w_hit  = wr_commit && (a_prev[15:4] == 12'd0);
    assign w_idx  = a_prev[3:0];
    assign hc_clr = (w_hit && w_idx == 4'd2) ? d_prev[7:0] : 8'd0;
    assign dc_clr = (w_hit && w_idx == 4'd4) ? d_prev[7:0] : 8'd0;

    always_ff @(posedge csi_clk) begin
        if (!rsi_rst_n) begin
            scratch <= '0;
            hc_sts  <= '0;
            hc_en   <= '0;
            dc_sts  <= '0;
            dc_en   <= '0;
            for (int i = 7; i < 16; i++) begin
                gp[i] <= '0;
            end
        end else begin
            // OR-ing events after the clear lets a same-cycle set win
            hc_sts <= (hc_sts & ~hc_clr) | evt_hc;
            dc_sts <= (dc_sts & ~dc_clr) | evt_dc;
            if (w_hit) begin
                unique case (w_idx)
                    4'd1: scratch <= d_prev;
                    4'd3: hc_en   <= d_prev[7:0];
                    4'd5: dc_en   <= d_prev[7:0];
                    4'd0, 4'd2, 4'd4, 4'd6: ;
                    default: gp[w_idx] <= d_prev;
                endcase
            end
        end
    end

    // DMA pacing
    logic dack_sel;
    assign dack_sel = dma_ch ? dk_s : hk_s;

    always_ff @(posedge csi_clk) begin
        if (!rsi_rst_n) begin
            dma_cnt <= '0;
            dma_ch  <= 1'b0;
        end else if (w_hit && w_idx == 4'd6) begin
            dma_cnt <= d_prev[15:0];
            dma_ch  <= d_prev[16];
        end else if ((wr_commit || rd_release) && dack_sel &&
                     dma_cnt != 16'd0) begin
            dma_cnt <= dma_cnt - 16'd1;
        end
    end

    // Read path
    logic [3:0]  rd_idx;
    logic        rd_ok;
    logic [31:0] rd_mux, rd_data;

    always_comb begin
        rd_mux = '0;
        unique case (rd_idx)
            4'd0:    rd_mux = CHIP_ID;
            4'd1:    rd_mux = scratch;
            4'd2:    rd_mux = {24'd0, hc_sts};
            4'd3:    rd_mux = {24'd0, hc_en};
            4'd4:    rd_mux = {24'd0, dc_sts};
            4'd5:    rd_mux = {24'd0, dc_en};
            4'd6:    rd_mux = {15'd0, dma_ch, dma_cnt};
            default: rd_mux = gp[rd_idx];
        endcase
    end

    always_ff @(posedge csi_clk) begin
        if (!rsi_rst_n) begin
            lat_cnt <= '0;
            rd_idx  <= '0;
            rd_ok   <= 1'b0;
            rd_data <= '0;
        end else begin
            if (rd_start) begin
                lat_cnt <= LAT_LOAD;
                rd_idx  <= a_s[3:0];
                rd_ok   <= (a_s[15:4] == 12'd0);
            end else if (state_q == RD_WAIT && lat_cnt != 3'd0) begin
                lat_cnt <= lat_cnt - 3'd1;
            end
            if (rd_fire) begin
                rd_data <= rd_ok ? rd_mux : 32'd0;
            end
        end
    end

    assign bus_d_oe = (state_q == RD_DRIVE);
    assign bus_d    = bus_d_oe ? rd_data : 32'bz;

    // Registered side-band outputs
    always_ff @(posedge csi_clk) begin
        if (!rsi_rst_n) begin
            bus_hc_irq  <= 1'b0;
            bus_dc_irq  <= 1'b0;
            bus_hc_dreq <= 1'b0;
            bus_dc_dreq <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            bus_hc_irq  <= |(hc_sts & hc_en);
            bus_dc_irq  <= |(dc_sts & dc_en);
            bus_hc_dreq <= (dma_cnt != 16'd0) && !dma_ch;
            bus_dc_dreq <= (dma_cnt != 16'd0) && dma_ch;
            if (err_set) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_isp1761_bus_responder.sv
// tb_isp1761_bus_responder: vector table, hand-written corner sequences
// and a randomized run against a transaction-level register model.
module tb_isp1761_bus_responder;

    localparam int          RD_LAT  = 2;
    localparam logic [31:0] CHIP_ID = 32'h0001_1761;
    localparam int          EXP_LAT = RD_LAT + 3;

    logic        clk, rst_n;
    logic        cs_n, wr_n, rd_n;
    logic [16:0] a;
    wire  [31:0] bus_d;
    logic [31:0] tb_d;
    logic        tb_doe;
    logic        hc_irq, dc_irq, hc_dreq, dc_dreq;
    logic        hc_dack, dc_dack;
    logic [7:0]  evt_hc, evt_dc;
    logic        d_oe, perr;

    assign bus_d = tb_doe ? tb_d : 32'bz;

    isp1761_bus_responder #(
        .CHIP_ID(CHIP_ID),
        .RD_LAT(RD_LAT),
        .SYNC_STAGES(2)
    ) dut (
        .csi_clk(clk),
        .rsi_rst_n(rst_n),
        .bus_cs_n(cs_n),
        .bus_wr_n(wr_n),
        .bus_rd_n(rd_n),
        .bus_a(a),
        .bus_d(bus_d),
        .bus_hc_irq(hc_irq),
        .bus_dc_irq(dc_irq),
        .bus_hc_dreq(hc_dreq),
        .bus_dc_dreq(dc_dreq),
        .bus_hc_dack(hc_dack),
        .bus_dc_dack(dc_dack),
        .evt_hc(evt_hc),
        .evt_dc(evt_dc),
        .bus_d_oe(d_oe),
        .proto_err(perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [16:0] ad, input logic [31:0] dat,
                             input logic [7:0] ehc);
        a = ad;
        tb_d = dat;
        tb_doe = 1'b1;
        cs_n = 1'b0;
        wr_n = 1'b0;
        repeat (4) @(negedge clk);
        wr_n = 1'b1;
        repeat (2) @(negedge clk);
        // lands on the edge at which the write commits
        evt_hc = ehc;
        @(negedge clk);
        evt_hc = 8'd0;
        cs_n = 1'b1;
        tb_doe = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic bus_read(input logic [16:0] ad, output logic [31:0] dat,
                            output int lat);
        lat = -1;
        dat = '0;
        a = ad;
        cs_n = 1'b0;
        rd_n = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (d_oe === 1'b1) begin
                lat = k;
                break;
            end
        end
        dat = bus_d;
        rd_n = 1'b1;
        cs_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    // Register model: index from byte address {A,0}, window = bits [17:6]
    logic [31:0] m_reg [16];

    function automatic bit m_win(input logic [16:0] ad);
        logic [17:0] b;
        b = {ad, 1'b0};
        return b[17:6] == 12'd0;
    endfunction

    function automatic int m_idx(input logic [16:0] ad);
        logic [17:0] b;
        b = {ad, 1'b0};
        return int'(b[5:2]);
    endfunction

    function automatic logic [31:0] m_read(input logic [16:0] ad);
        if (!m_win(ad)) return 32'd0;
        if (m_idx(ad) == 0) return CHIP_ID;
        return m_reg[m_idx(ad)];
    endfunction

    task automatic m_write(input logic [16:0] ad, input logic [31:0] dat);
        int i;
        if (!m_win(ad)) return;
        i = m_idx(ad);
        case (i)
            0: ;
            2, 4: m_reg[i] = m_reg[i] & ~{24'd0, dat[7:0]};
            3, 5: m_reg[i] = {24'd0, dat[7:0]};
            6: m_reg[i] = {15'd0, dat[16:0]};
            default: m_reg[i] = dat;
        endcase
    endtask

    typedef struct packed {
        logic        wr;
        logic [16:0] ad;
        logic [31:0] dat;
    } vec_t;

    vec_t        tbl [16];
    logic [31:0] got;
    int          lat;
    int          oe_cnt;
    bit          seen;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        cs_n = 1'b1;
        wr_n = 1'b1;
        rd_n = 1'b1;
        a = '0;
        tb_d = '0;
        tb_doe = 1'b0;
        hc_dack = 1'b0;
        dc_dack = 1'b0;
        evt_hc = '0;
        evt_dc = '0;

        tbl[0]  = '{1'b0, 17'h00, 32'h0001_1761};
        tbl[1]  = '{1'b0, 17'h02, 32'h0000_0000};
        tbl[2]  = '{1'b1, 17'h02, 32'hDEAD_BEEF};
        tbl[3]  = '{1'b0, 17'h02, 32'hDEAD_BEEF};
        tbl[4]  = '{1'b1, 17'h00, 32'hFFFF_FFFF};
        tbl[5]  = '{1'b0, 17'h00, 32'h0001_1761};
        tbl[6]  = '{1'b1, 17'h20, 32'h0BAD_F00D};
        tbl[7]  = '{1'b0, 17'h20, 32'h0000_0000};
        tbl[8]  = '{1'b0, 17'h02, 32'hDEAD_BEEF};
        tbl[9]  = '{1'b1, 17'h06, 32'hFFFF_FF04};
        tbl[10] = '{1'b0, 17'h06, 32'h0000_0004};
        tbl[11] = '{1'b1, 17'h1E, 32'hCAFE_0001};
        tbl[12] = '{1'b0, 17'h1E, 32'hCAFE_0001};
        tbl[13] = '{1'b0, 17'h0E, 32'h0000_0000};
        tbl[14] = '{1'b1, 17'h1F, 32'h5555_AAAA};
        tbl[15] = '{1'b0, 17'h1E, 32'h5555_AAAA};

        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_oe", d_oe, 0);
        chk("rst_irq", {hc_irq, dc_irq}, 0);
        chk("rst_dreq", {hc_dreq, dc_dreq}, 0);
        chk("rst_perr", perr, 0);

        for (int i = 0; i < 16; i++) begin
            if (tbl[i].wr) begin
                bus_write(tbl[i].ad, tbl[i].dat, 8'd0);
            end else begin
                bus_read(tbl[i].ad, got, lat);
                chk($sformatf("tbl%0d_data", i), got, tbl[i].dat);
                chk($sformatf("tbl%0d_lat", i), lat, EXP_LAT);
            end
        end

        // Interrupts
        bus_write(17'h06, 32'h4, 8'd0);
        evt_hc = 8'h05;
        @(negedge clk);
        evt_hc = 8'h00;
        chk("irq_not_early", hc_irq, 0);
        @(negedge clk);
        chk("irq_set", hc_irq, 1);
        bus_write(17'h04, 32'h4, 8'd0);
        chk("irq_w1c", hc_irq, 0);
        bus_read(17'h04, got, lat);
        chk("sts_after_w1c", got, 32'h1);
        evt_hc = 8'h04;
        @(negedge clk);
        evt_hc = 8'h00;
        bus_write(17'h04, 32'h4, 8'h04);
        bus_read(17'h04, got, lat);
        chk("sts_set_wins", got, 32'h5);
        chk("irq_set_wins", hc_irq, 1);
        bus_write(17'h0A, 32'h80, 8'd0);
        evt_dc = 8'h80;
        @(negedge clk);
        evt_dc = 8'h00;
        @(negedge clk);
        chk("dc_irq_set", dc_irq, 1);

        // DMA on the DC channel
        bus_write(17'h0C, 32'h0001_0003, 8'd0);
        chk("dma_dc_dreq_on", dc_dreq, 1);
        chk("dma_hc_idle0", hc_dreq, 0);
        dc_dack = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            bus_read(17'h02, got, lat);
            chk($sformatf("dma_rd%0d", n), got, 32'hDEAD_BEEF);
            chk($sformatf("dma_dreq%0d", n), dc_dreq, (n < 3) ? 1 : 0);
            chk($sformatf("dma_hc%0d", n), hc_dreq, 0);
        end
        dc_dack = 1'b0;
        repeat (2) @(negedge clk);
        bus_read(17'h0C, got, lat);
        chk("dma_ctrl_end", got, 32'h0001_0000);

        // Both strobes low together
        a = 17'h02;
        tb_d = 32'h1234_5678;
        tb_doe = 1'b1;
        cs_n = 1'b0;
        rd_n = 1'b0;
        wr_n = 1'b0;
        oe_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (d_oe) oe_cnt++;
        end
        chk("perr_flag", perr, 1);
        chk("perr_no_oe", oe_cnt, 0);
        rd_n = 1'b1;
        wr_n = 1'b1;
        cs_n = 1'b1;
        tb_doe = 1'b0;
        repeat (4) @(negedge clk);
        bus_read(17'h02, got, lat);
        chk("perr_no_write", got, 32'hDEAD_BEEF);
        chk("perr_next_lat", lat, EXP_LAT);
        chk("perr_sticky", perr, 1);

        // Reset in RD_DRIVE, strobe held low across reset release
        a = 17'h00;
        cs_n = 1'b0;
        rd_n = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (d_oe) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rst_drive_reached", seen, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_oe_drop", d_oe, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        oe_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (d_oe) oe_cnt++;
        end
        chk("rst_held_strobe", oe_cnt, 0);
        chk("rst_perr_clr", perr, 0);
        chk("rst_irq_clr", {hc_irq, dc_irq}, 0);
        rd_n = 1'b1;
        repeat (3) @(negedge clk);
        bus_read(17'h00, got, lat);
        chk("rst_rearm_data", got, CHIP_ID);
        chk("rst_rearm_lat", lat, EXP_LAT);
        bus_read(17'h02, got, lat);
        chk("rst_scratch", got, 32'h0);

        // Randomized run; model starts from the reset state
        for (int i = 0; i < 16; i++) m_reg[i] = '0;
        for (int n = 0; n < 48; n++) begin
            logic [16:0] ad;
            logic [31:0] dat, expv;
            logic [7:0]  e1, e2;
            bit          wr, dk;
            e1 = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'd0;
            e2 = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'd0;
            evt_hc = e1;
            evt_dc = e2;
            @(negedge clk);
            evt_hc = 8'd0;
            evt_dc = 8'd0;
            m_reg[2][7:0] = m_reg[2][7:0] | e1;
            m_reg[4][7:0] = m_reg[4][7:0] | e2;
            hc_dack = 1'($urandom_range(0, 1));
            dc_dack = 1'($urandom_range(0, 1));
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                ad = 17'($urandom) | 17'h20;
            end else begin
                ad = 17'($urandom_range(0, 31));
            end
            dat = $urandom;
            wr = 1'($urandom_range(0, 1));
            dk = m_reg[6][16] ? dc_dack : hc_dack;
            if (wr) begin
                bus_write(ad, dat, 8'd0);
                m_write(ad, dat);
            end else begin
                expv = m_read(ad);
                bus_read(ad, got, lat);
                chk($sformatf("rnd%0d_rd_%h", n, ad), got, expv);
                chk($sformatf("rnd%0d_lat", n), lat, EXP_LAT);
            end
            if (!(wr && m_win(ad) && m_idx(ad) == 6) && dk &&
                m_reg[6][15:0] != 16'd0) begin
                m_reg[6][15:0] = m_reg[6][15:0] - 16'd1;
            end
            chk($sformatf("rnd%0d_hc_irq", n), hc_irq,
                |(m_reg[2][7:0] & m_reg[3][7:0]));
            chk($sformatf("rnd%0d_dc_irq", n), dc_irq,
                |(m_reg[4][7:0] & m_reg[5][7:0]));
            chk($sformatf("rnd%0d_hc_dreq", n), hc_dreq,
                (m_reg[6][15:0] != 0) && !m_reg[6][16]);
            chk($sformatf("rnd%0d_dc_dreq", n), dc_dreq,
                (m_reg[6][15:0] != 0) && m_reg[6][16]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
